// File: rtl/imem_loader.sv
// Instruction memory loader: accepts a program as a byte stream, then serves
// 10-byte instruction windows to fetch by PC. Holds the CPU until a complete
// program has been loaded.
module imem_loader #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              load_done,
    output logic              load_error,
    output logic              cpu_hold,
    input  logic [63:0]       PC,
    output logic [79:0]       instr_bytes,
    output logic              imem_error
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    localparam logic [ADDR_W:0] MEM_LEN = (ADDR_W + 1)'(MEM_BYTES);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

    state_t          state_reg, state_next;
    logic [ADDR_W:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W:0] len_reg, len_next;
    logic            in_ready_reg, in_ready_next;
    logic            load_done_reg, load_done_next;
    logic            load_error_reg, load_error_next;
    logic            cpu_hold_reg, cpu_hold_next;

    // Program storage; deliberately not cleared by reset so a reset mid-load
    // leaves earlier contents in place.
    logic [7:0] mem [MEM_BYTES];

    logic len_legal;
    logic wr_en;

    assign len_legal = (load_len != '0) && (load_len <= MEM_LEN);
    assign wr_en     = (state_reg == LOAD) && in_valid && in_ready_reg;

    // State and control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            len_reg        <= '0;
            in_ready_reg   <= 1'b0;
            load_done_reg  <= 1'b0;
            load_error_reg <= 1'b0;
            cpu_hold_reg   <= 1'b1;
        end else begin
            state_reg      <= state_next;
            wr_ptr_reg     <= wr_ptr_next;
            len_reg        <= len_next;
            in_ready_reg   <= in_ready_next;
            load_done_reg  <= load_done_next;
            load_error_reg <= load_error_next;
            cpu_hold_reg   <= cpu_hold_next;
        end
    end

    // Next-state logic: start/restart loads, count accepted bytes, finish.
    always_comb begin
        state_next      = state_reg;
        wr_ptr_next     = wr_ptr_reg;
        len_next        = len_reg;
        in_ready_next   = in_ready_reg;
        load_done_next  = load_done_reg;
        load_error_next = load_error_reg;
        cpu_hold_next   = cpu_hold_reg;
        case (state_reg)
            IDLE, RUN: begin
                if (load_start) begin
                    if (len_legal) begin
                        state_next      = LOAD;
                        len_next        = load_len;
                        wr_ptr_next     = '0;
                        in_ready_next   = 1'b1;
                        load_error_next = 1'b0;
                        load_done_next  = 1'b0;
                        cpu_hold_next   = 1'b1;
                    end else begin
                        // Illegal length leaves state and any loaded program intact.
                        load_error_next = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (wr_en) begin
                    wr_ptr_next = wr_ptr_reg + ONE;
                    if (wr_ptr_reg == len_reg - ONE) begin
                        state_next     = RUN;
                        in_ready_next  = 1'b0;
                        load_done_next = 1'b1;
                        cpu_hold_next  = 1'b0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Byte write port; wr_ptr stays below len_reg <= MEM_BYTES while writing.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[ADDR_W-1:0]] <= in_byte;
        end
    end

    // Ten combinational read lanes; the sum is 65 bits wide so a PC near the
    // top of the 64-bit space cannot wrap back into the array.
    for (genvar gi = 0; gi < 10; gi++) begin : g_rd
        logic [64:0] addr;
        assign addr = {1'b0, PC} + 65'(gi);
        assign instr_bytes[8*gi +: 8] = (addr < 65'(MEM_BYTES)) ? mem[addr[ADDR_W-1:0]] : 8'h00;
    end

    assign imem_error = cpu_hold_reg | (PC > 64'(MEM_BYTES - 1));

    assign in_ready   = in_ready_reg;
    assign load_done  = load_done_reg;
    assign load_error = load_error_reg;
    assign cpu_hold   = cpu_hold_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: loads programs through the byte stream,
// keeps a shadow copy of memory, and scoreboards fetch windows against it.
module tb_imem_loader;

    localparam int MEM = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0;
    logic [10:0] load_len = '0;
    logic [7:0]  in_byte = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        load_done;
    logic        load_error;
    logic        cpu_hold;
    logic [63:0] PC = '0;
    logic [79:0] instr_bytes;
    logic        imem_error;

    typedef struct {
        logic [63:0] pc;
        logic [79:0] data;
        logic        err;
    } fetch_t;

    fetch_t     exp_q [$];
    logic [7:0] model_mem [MEM];
    logic [7:0] src [MEM];
    logic       exp_hold = 1'b1;
    int         n_cmp = 0;
    int         n_fail = 0;

    imem_loader #(.MEM_BYTES(MEM), .ADDR_W(10)) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .load_len(load_len),
        .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .load_done(load_done), .load_error(load_error), .cpu_hold(cpu_hold),
        .PC(PC), .instr_bytes(instr_bytes), .imem_error(imem_error)
    );

    always #5 clk = ~clk;

    // Expected fetch window from the shadow memory.
    function automatic fetch_t predict(input logic [63:0] pc);
        fetch_t f;
        logic [64:0] a;
        f.pc = pc;
        f.data = '0;
        for (int i = 0; i < 10; i++) begin
            a = {1'b0, pc} + 65'(i);
            if (a < 65'(MEM)) f.data[8*i +: 8] = model_mem[a[9:0]];
        end
        f.err = exp_hold || (pc > 64'(MEM - 1));
        return f;
    endfunction

    // Start a load of src[0..len-1]; gapped drops in_valid on odd cycles.
    // Returns the number of edges after the start edge until load_done shows.
    task automatic run_load(input int len, input bit gapped, output int edges);
        int  idx;
        logic v;
        @(negedge clk);
        load_start = 1'b1;
        load_len = 11'(len);
        @(negedge clk);
        load_start = 1'b0;
        exp_hold = 1'b1;
        edges = 0;
        idx = 0;
        while (load_done !== 1'b1 && edges < 4 * len + 20) begin
            v = (idx < len) && (!gapped || ((edges + 1) % 2 == 0));
            in_valid = v;
            in_byte = (idx < len) ? src[idx] : 8'h00;
            @(negedge clk);
            edges++;
            if (v) begin
                model_mem[idx] = src[idx];
                idx++;
            end
        end
        in_valid = 1'b0;
        if (load_done !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL load_timeout len=%0d load_done=%b required 1", len, load_done);
        end else begin
            exp_hold = 1'b0;
        end
        $display("load len=%0d gapped=%0d done_after=%0d", len, gapped, edges);
    endtask

    task automatic test_reset();
        fetch_t e;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_hold = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        n_cmp++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL rst_load_done got=%b exp=0", load_done); end
        n_cmp++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_hold got=%b exp=1", cpu_hold); end
        n_cmp++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL rst_load_error got=%b exp=0", load_error); end
        PC = 64'd0;
        exp_q.push_back(predict(64'd0));
        #1;
        e = exp_q.pop_front();
        n_cmp++; if (imem_error !== e.err) begin n_fail++; $display("FAIL rst_imem_error got=%b exp=%b", imem_error, e.err); end
        $display("reset check pc=0 imem_error=%b", imem_error);
        // Illegal length from IDLE: error flagged, nothing else moves.
        @(negedge clk);
        load_start = 1'b1;
        load_len = 11'd0;
        @(negedge clk);
        load_start = 1'b0;
        n_cmp++; if (load_error !== 1'b1) begin n_fail++; $display("FAIL idle_len0_error got=%b exp=1", load_error); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_len0_ready got=%b exp=0", in_ready); end
        n_cmp++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL idle_len0_hold got=%b exp=1", cpu_hold); end
        $display("idle illegal len=0 load_error=%b", load_error);
    endtask

    task automatic test_load_b2b();
        int edges;
        fetch_t e;
        src[0] = 8'h30; src[1] = 8'hF3; src[2] = 8'h0A; src[3] = 8'h00;
        run_load(4, 1'b0, edges);
        n_cmp++; if (edges !== 4) begin n_fail++; $display("FAIL b2b_done_cycle got=%0d exp=4", edges); end
        n_cmp++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL b2b_cpu_hold got=%b exp=0", cpu_hold); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready got=%b exp=0", in_ready); end
        n_cmp++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL b2b_error_clear got=%b exp=0", load_error); end
        PC = 64'd0;
        exp_q.push_back(predict(64'd0));
        #1;
        e = exp_q.pop_front();
        n_cmp++; if (instr_bytes !== e.data) begin n_fail++; $display("FAIL b2b_data got=%h exp=%h", instr_bytes, e.data); end
        n_cmp++; if (instr_bytes[31:0] !== 32'h000AF330) begin n_fail++; $display("FAIL b2b_word got=%h exp=000af330", instr_bytes[31:0]); end
        n_cmp++; if (instr_bytes[79:32] !== 48'h0) begin n_fail++; $display("FAIL b2b_tail got=%h exp=0", instr_bytes[79:32]); end
        n_cmp++; if (imem_error !== e.err) begin n_fail++; $display("FAIL b2b_err got=%b exp=%b", imem_error, e.err); end
        $display("fetch pc=%h data=%h err=%b", PC, instr_bytes, imem_error);
    endtask

    task automatic test_load_gapped();
        int edges;
        fetch_t e;
        logic [63:0] pcs [$];
        run_load(4, 1'b1, edges);
        n_cmp++; if (edges !== 8) begin n_fail++; $display("FAIL gap_done_cycle got=%0d exp=8", edges); end
        pcs = '{64'd0, 64'd2};
        foreach (pcs[k]) begin
            @(negedge clk);
            PC = pcs[k];
            exp_q.push_back(predict(pcs[k]));
            #1;
            e = exp_q.pop_front();
            n_cmp++; if (instr_bytes !== e.data) begin n_fail++; $display("FAIL gap_data pc=%h got=%h exp=%h", e.pc, instr_bytes, e.data); end
            n_cmp++; if (imem_error !== e.err) begin n_fail++; $display("FAIL gap_err pc=%h got=%b exp=%b", e.pc, imem_error, e.err); end
            $display("fetch pc=%h data=%h err=%b", PC, instr_bytes, imem_error);
        end
    endtask

    task automatic test_illegal_len();
        fetch_t e;
        int lens [2];
        lens = '{0, MEM + 1};
        foreach (lens[k]) begin
            @(negedge clk);
            load_start = 1'b1;
            load_len = 11'(lens[k]);
            in_valid = 1'b1;
            in_byte = 8'hFF;
            @(negedge clk);
            load_start = 1'b0;
            @(negedge clk);
            in_valid = 1'b0;
            n_cmp++; if (load_error !== 1'b1) begin n_fail++; $display("FAIL ill_error len=%0d got=%b exp=1", lens[k], load_error); end
            n_cmp++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL ill_done len=%0d got=%b exp=1", lens[k], load_done); end
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ill_ready len=%0d got=%b exp=0", lens[k], in_ready); end
            n_cmp++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL ill_hold len=%0d got=%b exp=0", lens[k], cpu_hold); end
            $display("illegal len=%0d load_error=%b load_done=%b", lens[k], load_error, load_done);
        end
        // Bytes offered while not ready must not have landed.
        PC = 64'd0;
        exp_q.push_back(predict(64'd0));
        #1;
        e = exp_q.pop_front();
        n_cmp++; if (instr_bytes !== e.data) begin n_fail++; $display("FAIL ill_mem got=%h exp=%h", instr_bytes, e.data); end
        $display("fetch pc=%h data=%h err=%b", PC, instr_bytes, imem_error);
    endtask

    task automatic test_full_load();
        int edges;
        fetch_t e;
        logic [63:0] pcs [$];
        for (int i = 0; i < MEM; i++) src[i] = 8'($urandom_range(1, 255));
        run_load(MEM, 1'b0, edges);
        n_cmp++; if (edges !== MEM) begin n_fail++; $display("FAIL full_done_cycle got=%0d exp=%0d", edges, MEM); end
        n_cmp++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL full_error got=%b exp=0", load_error); end
        pcs = '{64'(MEM - 10), 64'(MEM - 3), 64'(MEM), 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd517};
        foreach (pcs[k]) begin
            @(negedge clk);
            PC = pcs[k];
            exp_q.push_back(predict(pcs[k]));
            #1;
            e = exp_q.pop_front();
            n_cmp++; if (instr_bytes !== e.data) begin n_fail++; $display("FAIL full_data pc=%h got=%h exp=%h", e.pc, instr_bytes, e.data); end
            n_cmp++; if (imem_error !== e.err) begin n_fail++; $display("FAIL full_err pc=%h got=%b exp=%b", e.pc, imem_error, e.err); end
            $display("fetch pc=%h data=%h err=%b", PC, instr_bytes, imem_error);
        end
    endtask

    task automatic test_reset_midload();
        int edges;
        fetch_t e;
        @(negedge clk);
        load_start = 1'b1;
        load_len = 11'd4;
        @(negedge clk);
        load_start = 1'b0;
        src[0] = 8'hAA; src[1] = 8'hBB;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_byte = src[i];
            @(negedge clk);
            model_mem[i] = src[i];
        end
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_hold = 1'b1;
        n_cmp++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL mid_hold got=%b exp=1", cpu_hold); end
        n_cmp++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL mid_done got=%b exp=0", load_done); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready got=%b exp=0", in_ready); end
        PC = 64'd0;
        exp_q.push_back(predict(64'd0));
        #1;
        e = exp_q.pop_front();
        n_cmp++; if (instr_bytes !== e.data) begin n_fail++; $display("FAIL mid_data got=%h exp=%h", instr_bytes, e.data); end
        n_cmp++; if (imem_error !== e.err) begin n_fail++; $display("FAIL mid_err got=%b exp=%b", imem_error, e.err); end
        $display("fetch pc=%h data=%h err=%b", PC, instr_bytes, imem_error);
        src[0] = 8'h11; src[1] = 8'h22;
        run_load(2, 1'b0, edges);
        n_cmp++; if (edges !== 2) begin n_fail++; $display("FAIL reload_done_cycle got=%0d exp=2", edges); end
        PC = 64'd0;
        exp_q.push_back(predict(64'd0));
        #1;
        e = exp_q.pop_front();
        n_cmp++; if (instr_bytes !== e.data) begin n_fail++; $display("FAIL reload_data got=%h exp=%h", instr_bytes, e.data); end
        n_cmp++; if (imem_error !== e.err) begin n_fail++; $display("FAIL reload_err got=%b exp=%b", imem_error, e.err); end
        $display("fetch pc=%h data=%h err=%b", PC, instr_bytes, imem_error);
    endtask

    initial begin
        for (int i = 0; i < MEM; i++) model_mem[i] = 8'h00;
        test_reset();
        test_load_b2b();
        test_load_gapped();
        test_illegal_len();
        test_full_load();
        test_reset_midload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
